brick_field_ctrl: RTL and testbench
===================================

# brick_field_ctrl

Parametrised brick-field controller for the Breakout datapath: it holds a ROWS x COLS grid of multi-hit bricks, applies ball collisions reported by the collision checker, and accumulates a saturating score. It also tracks the number of live bricks and flags level clear. It sits between the collision checker and the VGA renderer/score display. It adds several capabilities over a fixed single-hit 8x8 field: per-brick hit points, level loading, row-weighted points and a live-brick count.

## Interface
Parameters:
- ROWS, 8, brick rows; row 0 is the top row.
- COLS, 8, brick columns.
- HP_W, 2, width of each brick's hit-point field; HP 0 means no brick.
- SCORE_W, 16, width of the accumulated score.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- load  in  1  one-cycle pulse; loads `level_map` into the field.
- level_map  in  ROWS*COLS*HP_W  initial HP per brick; brick (r,c) is at bits [(r*COLS+c)*HP_W +: HP_W].
- collision  in  1  one-cycle pulse; the ball hit cell (`hit_row`,`hit_col`).
- hit_row  in  clog2(ROWS)  row of the hit; valid when `collision`=1.
- hit_col  in  clog2(COLS)  column of the hit; valid when `collision`=1.
- brk_en  out  ROWS*COLS  bit r*COLS+c is 1 when brick (r,c) has HP≠0; drives the renderer.
- brk_hp  out  ROWS*COLS*HP_W  current HP per brick, packed the same way as `level_map`.
- score  out  1  one-cycle pulse; a brick was destroyed.
- hit_ack  out  1  one-cycle pulse; the collision landed on a live brick (damaged or destroyed).
- points  out  SCORE_W  accumulated score.
- bricks_left  out  clog2(ROWS*COLS+1)  count of bricks with HP≠0.
- no_brks  out  1  level clear; asserted only in state CLEAR.

## Operation
State machine:
- IDLE → LOAD on `load`.
- LOAD → PLAY unconditionally after one cycle.
- PLAY → CLEAR when `bricks_left`=0.
- PLAY or CLEAR → LOAD on `load`.

LOAD:
- Copies `level_map` into the HP array.
- Sets `bricks_left` to the number of nonzero entries.
- Clears `points`.

PLAY, collision at (r,c):
- Out of range (r≥ROWS or c≥COLS), or HP=0: ignored; no pulses, no state change.
- HP>1: HP decrements; `hit_ack` pulses; `score` stays 0; `points` unchanged.
- HP=1: HP becomes 0; `hit_ack` and `score` pulse; `bricks_left` decrements; `points` increases by ROWS−r.

Score arithmetic:
- `points` addition saturates at 2^SCORE_W−1 and never wraps.
- `bricks_left` cannot underflow: it decrements only on a destroy, and a destroy requires a live brick.

Ignored inputs:
- Collisions in IDLE, LOAD or CLEAR are ignored.
- `load` in LOAD is ignored.
- `load` and `collision` in the same cycle: `load` wins and the collision is dropped.

Level-clear edge cases:
- A load whose `level_map` is all zero gives LOAD → PLAY → CLEAR on the following cycle.
- `no_brks` asserts with that transition.

## Timing
Reset (`rst`=0, asynchronous):
- state = IDLE.
- All HP = 0, so `brk_en` = 0 and `brk_hp` = 0.
- `points` = 0, `bricks_left` = 0.
- `score` = `hit_ack` = `no_brks` = 0.

Reset behaviour:
- Reset asserted mid-level clears everything immediately.
- After release the block waits in IDLE for `load`.

Collision latency:
- Collision sampled at edge N: `brk_hp`, `brk_en`, `bricks_left` and `points` update at edge N.
- They are visible in the cycle after N, together with the `score`/`hit_ack` pulses.
- Collisions on consecutive cycles are all accepted; there is no busy state.
- A second hit to the same brick on the next cycle sees the already-decremented HP.

Load latency:
- `load` sampled at edge N: state = LOAD and the array is loaded at edge N.
- State = PLAY at edge N+1.
- The first collision accepted is the one sampled at edge N+2.

Level-clear latency:
- The final destroy at edge N gives `bricks_left`=0 after N.
- State = CLEAR and `no_brks`=1 after edge N+1.
- `no_brks` holds until the next `load` or reset.

All outputs are registered; there are no combinational input→output paths.

## Test plan
- **Reset/idle:** assert `rst`=0 mid-operation → all outputs 0 asynchronously; collisions at (0,0) before any load → no pulses, `points`=0.
- **Single-hit clear (defaults ROWS=COLS=8, HP_W=2):** load a map with only brick (7,3) HP=1.
  - Collide at (7,3) → `score`=1, `hit_ack`=1, `points`=1, `bricks_left`=0.
  - `no_brks`=1 one cycle later.
- **Multi-hit brick:** brick (0,0) HP=3, hits on 3 consecutive cycles.
  - `hit_ack` pulses 3 times; `score` pulses on the 3rd hit only.
  - `points`=8; `brk_en` bit 0 clears after the 3rd hit.
- **Miss cases:** collide at an empty cell, then at (0,0) on a destroyed brick → no pulses, counters unchanged.
- **Same-cycle load+collision in PLAY:** `load` wins → HP array equals the new map and `points`=0.
- **Saturation:** SCORE_W=3, full map HP=1, destroy row-0 bricks (8 points each) → `points` stays 7 after the first destroy.

Source files
------------

// File: rtl/brick_field_ctrl.sv
// Breakout brick-field controller: multi-hit brick grid, level loading,
// row-weighted saturating score, live-brick count and level-clear flag.
module brick_field_ctrl #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int HP_W    = 2,
  parameter int SCORE_W = 16,
  localparam int NCELL  = ROWS * COLS,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int BL_W   = $clog2(NCELL + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [NCELL*HP_W-1:0]   level_map,
  input  logic                    collision,
  input  logic [ROW_W-1:0]        hit_row,
  input  logic [COL_W-1:0]        hit_col,
  output logic [NCELL-1:0]        brk_en,
  output logic [NCELL*HP_W-1:0]   brk_hp,
  output logic                    score,
  output logic                    hit_ack,
  output logic [SCORE_W-1:0]      points,
  output logic [BL_W-1:0]         bricks_left,
  output logic                    no_brks
);

  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int PTS_W = $clog2(ROWS + 1);
  // One spare bit above the wider operand so an overflow is always visible.
  localparam int SUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]       state;
  logic [BL_W-1:0]  load_count;
  logic             load_take;
  logic             hit_valid;
  logic [IDX_W-1:0] hit_idx;
  logic [HP_W-1:0]  hit_hp;
  logic [SUM_W-1:0] score_sum;

  // Live-brick count of the incoming map, latched alongside the map on load.
  always_comb begin
    load_count = '0;
    for (int i = 0; i < NCELL; i++) begin
      if (level_map[i*HP_W +: HP_W] != '0) load_count = load_count + BL_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit_idx   = '0;
    hit_hp    = '0;
    hit_valid = 1'b0;
    if (int'(hit_row) < ROWS && int'(hit_col) < COLS) begin
      hit_idx   = IDX_W'(int'(hit_row) * COLS + int'(hit_col));
      hit_hp    = brk_hp[hit_idx*HP_W +: HP_W];
      hit_valid = collision && (state == S_PLAY) && (hit_hp != '0);
    end
    score_sum = SUM_W'(points) + SUM_W'(ROWS - int'(hit_row));
  end

  // Load is honoured everywhere except while a load is already in progress.
  assign load_take = load && (state != S_LOAD);

  always_comb begin
    brk_en = '0;
    for (int i = 0; i < NCELL; i++) brk_en[i] = |brk_hp[i*HP_W +: HP_W];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      // NOTE: the HP array is reset, not left undefined: the renderer reads
      // brk_en straight out of reset and must see an empty field.
      brk_hp      <= '0;
      points      <= '0;
      bricks_left <= '0;
      score       <= 1'b0;
      hit_ack     <= 1'b0;
      no_brks     <= 1'b0;
    end else begin
      score   <= 1'b0;
      hit_ack <= 1'b0;
      if (load_take) begin
        // A same-cycle collision is dropped here because hit handling sits in the else.
        state       <= S_LOAD;
        brk_hp      <= level_map;
        bricks_left <= load_count;
        points      <= '0;
        no_brks     <= 1'b0;
      end else begin
        case (state)
          S_LOAD: state <= S_PLAY;
          S_PLAY: begin
            if (bricks_left == '0) begin
              state   <= S_CLEAR;
              no_brks <= 1'b1;
            end
          end
          default: ;
        endcase

        if (hit_valid) begin
          hit_ack <= 1'b1;
          brk_hp[hit_idx*HP_W +: HP_W] <= hit_hp - HP_W'(1);
          if (hit_hp == HP_W'(1)) begin
            score       <= 1'b1;
            bricks_left <= bricks_left - BL_W'(1);
            if (score_sum[SUM_W-1:SCORE_W] != '0) points <= '1;
            else                                   points <= score_sum[SCORE_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Self-checking bench for brick_field_ctrl: directed vector table, hand-written
// corner sequences, then random play against a grid-level reference model.
module tb_brick_field_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int HP_W = 2;
  localparam int NB   = ROWS * COLS * HP_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load = 1'b0;
  logic [NB-1:0]  level_map = '0;
  logic           collision = 1'b0;
  logic [2:0]     hit_row = '0;
  logic [2:0]     hit_col = '0;

  logic [63:0]    brk_en, s_brk_en;
  logic [NB-1:0]  brk_hp, s_brk_hp;
  logic           score, s_score, hit_ack, s_hit_ack, no_brks, s_no_brks;
  logic [15:0]    points;
  logic [2:0]     s_points;
  logic [6:0]     bricks_left, s_bricks_left;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  brick_field_ctrl dut (
    .clk(clk), .rst(rst), .load(load), .level_map(level_map),
    .collision(collision), .hit_row(hit_row), .hit_col(hit_col),
    .brk_en(brk_en), .brk_hp(brk_hp), .score(score), .hit_ack(hit_ack),
    .points(points), .bricks_left(bricks_left), .no_brks(no_brks)
  );

  brick_field_ctrl #(.SCORE_W(3)) dut_sat (
    .clk(clk), .rst(rst), .load(load), .level_map(level_map),
    .collision(collision), .hit_row(hit_row), .hit_col(hit_col),
    .brk_en(s_brk_en), .brk_hp(s_brk_hp), .score(s_score), .hit_ack(s_hit_ack),
    .points(s_points), .bricks_left(s_bricks_left), .no_brks(s_no_brks)
  );

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_LOAD, M_PLAY, M_CLEAR} mmode_t;
  mmode_t m_mode;
  int     m_hp [ROWS][COLS];
  int     m_left;
  longint m_pts;
  bit     m_score, m_ack;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_pts = 0; m_score = 0; m_ack = 0;
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) m_hp[i][j] = 0;
  endtask

  task automatic model_step(input bit ld, input logic [NB-1:0] map, input bit col,
                            input int r, input int c);
    m_score = 0; m_ack = 0;
    if (ld && m_mode != M_LOAD) begin
      m_left = 0; m_pts = 0; m_mode = M_LOAD;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          m_hp[i][j] = int'(map[(i*COLS+j)*HP_W +: HP_W]);
          if (m_hp[i][j] != 0) m_left++;
        end
    end else if (m_mode == M_LOAD) begin
      m_mode = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (m_left == 0) m_mode = M_CLEAR;
      if (col && r < ROWS && c < COLS && m_hp[r][c] > 0) begin
        m_ack = 1;
        m_hp[r][c]--;
        if (m_hp[r][c] == 0) begin
          m_score = 1; m_left--; m_pts += ROWS - r;
        end
      end
    end
  endtask

  function automatic logic [NB-1:0] model_hp_vec();
    logic [NB-1:0] v = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) v[(i*COLS+j)*HP_W +: HP_W] = HP_W'(m_hp[i][j]);
    return v;
  endfunction

  function automatic logic [63:0] model_en_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) v[i*COLS+j] = (m_hp[i][j] != 0);
    return v;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " score"},       score,       m_score);
    check({tag, " hit_ack"},     hit_ack,     m_ack);
    check({tag, " points"},      points,      NB'(sat(m_pts, 65535)));
    check({tag, " sat_points"},  s_points,    NB'(sat(m_pts, 7)));
    check({tag, " bricks_left"}, bricks_left, NB'(m_left));
    check({tag, " no_brks"},     no_brks,     m_mode == M_CLEAR);
    check({tag, " brk_hp"},      brk_hp,      model_hp_vec());
    check({tag, " brk_en"},      brk_en,      model_en_vec());
    check({tag, " sat_brk_hp"},  s_brk_hp,    model_hp_vec());
  endtask

  task automatic check_zero(input string tag);
    check({tag, " brk_en"},      brk_en,      '0);
    check({tag, " brk_hp"},      brk_hp,      '0);
    check({tag, " points"},      points,      '0);
    check({tag, " sat_points"},  s_points,    '0);
    check({tag, " bricks_left"}, bricks_left, '0);
    check({tag, " pulses"},      {score, hit_ack, no_brks}, '0);
  endtask

  task automatic drive(input bit ld, input logic [NB-1:0] map, input bit col,
                       input int r, input int c);
    load = ld; level_map = map; collision = col;
    hit_row = 3'(r); hit_col = 3'(c);
    @(posedge clk);
    model_step(ld, map, col, r, c);
    #1;
  endtask

  task automatic cycle(input string tag, input bit ld, input logic [NB-1:0] map,
                       input bit col, input int r, input int c);
    drive(ld, map, col, r, c);
    check_all(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            ld;
    logic [NB-1:0] map;
    bit            col;
    int            r, c;
    bit            e_score, e_ack;
    int            e_pts, e_left;
    bit            e_nob;
    logic [NB-1:0] e_hp;
  } vec_t;

  function automatic vec_t mk(bit ld, logic [NB-1:0] map, bit col, int r, int c,
                              bit es, bit ea, int ep, int el, bit en, logic [NB-1:0] eh);
    vec_t v;
    v.ld = ld; v.map = map; v.col = col; v.r = r; v.c = c;
    v.e_score = es; v.e_ack = ea; v.e_pts = ep; v.e_left = el; v.e_nob = en; v.e_hp = eh;
    return v;
  endfunction

  logic [NB-1:0] map1, map2, full1, rmap;
  vec_t vecs[21];

  initial begin
    map1  = NB'(1) << 118;                 // brick (7,3) HP=1
    map2  = (NB'(1) << 18) | NB'(3);       // (0,0) HP=3, (1,1) HP=1
    full1 = {(NB/2){2'b01}};               // every brick HP=1

    vecs[0]  = mk(0, '0,   1, 0, 0, 0, 0, 0, 0, 0, '0);
    vecs[1]  = mk(1, map1, 0, 0, 0, 0, 0, 0, 1, 0, map1);
    vecs[2]  = mk(0, '0,   1, 7, 3, 0, 0, 0, 1, 0, map1);
    vecs[3]  = mk(0, '0,   0, 0, 0, 0, 0, 0, 1, 0, map1);
    vecs[4]  = mk(0, '0,   1, 7, 3, 1, 1, 1, 0, 0, '0);
    vecs[5]  = mk(0, '0,   0, 0, 0, 0, 0, 1, 0, 1, '0);
    vecs[6]  = mk(0, '0,   1, 7, 3, 0, 0, 1, 0, 1, '0);
    vecs[7]  = mk(1, map2, 0, 0, 0, 0, 0, 0, 2, 0, map2);
    vecs[8]  = mk(0, '0,   0, 0, 0, 0, 0, 0, 2, 0, map2);
    vecs[9]  = mk(0, '0,   1, 0, 0, 0, 1, 0, 2, 0, (NB'(1) << 18) | NB'(2));
    vecs[10] = mk(0, '0,   1, 0, 0, 0, 1, 0, 2, 0, (NB'(1) << 18) | NB'(1));
    vecs[11] = mk(0, '0,   1, 0, 0, 1, 1, 8, 1, 0, NB'(1) << 18);
    vecs[12] = mk(0, '0,   1, 0, 0, 0, 0, 8, 1, 0, NB'(1) << 18);
    vecs[13] = mk(0, '0,   1, 5, 5, 0, 0, 8, 1, 0, NB'(1) << 18);
    vecs[14] = mk(1, map1, 1, 1, 1, 0, 0, 0, 1, 0, map1);
    vecs[15] = mk(1, map2, 0, 0, 0, 0, 0, 0, 1, 0, map1);
    vecs[16] = mk(0, '0,   1, 7, 3, 1, 1, 1, 0, 0, '0);
    vecs[17] = mk(0, '0,   0, 0, 0, 0, 0, 1, 0, 1, '0);
    vecs[18] = mk(1, '0,   0, 0, 0, 0, 0, 0, 0, 0, '0);
    vecs[19] = mk(0, '0,   0, 0, 0, 0, 0, 0, 0, 0, '0);
    vecs[20] = mk(0, '0,   0, 0, 0, 0, 0, 0, 0, 1, '0);

    model_reset();
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].ld, vecs[i].map, vecs[i].col, vecs[i].r, vecs[i].c);
      check({t, " score"},       score,       vecs[i].e_score);
      check({t, " hit_ack"},     hit_ack,     vecs[i].e_ack);
      check({t, " points"},      points,      NB'(vecs[i].e_pts));
      check({t, " sat_points"},  s_points,    NB'(sat(vecs[i].e_pts, 7)));
      check({t, " bricks_left"}, bricks_left, NB'(vecs[i].e_left));
      check({t, " no_brks"},     no_brks,     vecs[i].e_nob);
      check({t, " brk_hp"},      brk_hp,      vecs[i].e_hp);
    end

    // Saturation: full HP=1 field, destroy row-0 bricks on consecutive cycles.
    cycle("sat_load", 1, full1, 0, 0, 0);
    cycle("sat_play", 0, '0, 0, 0, 0);
    for (int j = 0; j < 4; j++) cycle($sformatf("sat_hit%0d", j), 0, '0, 1, 0, j);

    // Asynchronous reset mid-level, then collisions before any load.
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cycle("idle_hit0", 0, '0, 1, 0, 0);
    cycle("idle_hit1", 0, '0, 1, 0, 0);

    // Random play against the model.
    for (int n = 0; n < 3000; n++) begin
      bit ld;
      ld = ($urandom_range(0, 59) == 0) || (n == 0);
      for (int k = 0; k < NB / 32; k++) rmap[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) rmap = rmap & {(NB/2){2'b01}};
      cycle($sformatf("rnd%0d", n), ld, rmap, $urandom_range(0, 3) != 0,
            $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
